brick_draw: RTL
===============

BRICK_DRAW -- requirements
Module: brick_draw

Interface
REQ-001 Parameter COLS, default 8: brick columns.
REQ-002 Parameter ROWS, default 4: brick rows.
REQ-003 Parameter BRICK_W, default 20: horizontal pitch in pixels; drawn width is BRICK_W-1.
REQ-004 Parameter BRICK_H, default 5: vertical pitch in pixels; drawn height is BRICK_H-1.
REQ-005 Parameter Y_ORIGIN, default 10: y of the top row.
REQ-006 clk  in  1  clock; reset resetn, synchronous, active-low.
REQ-007 resetn  in  1  synchronous active-low reset.
REQ-008 go  in  1  single-cycle pulse that starts one full brick-field draw pass.
REQ-009 hit  in  1  single-cycle probe strobe from ball logic.
REQ-010 hit_x, hit_y  in  10 each  pixel coordinate to probe.
REQ-011 writeEn  out  1  pixel write strobe to draw_mux.
REQ-012 x_out, y_out  out  10 each  pixel coordinate, valid while writeEn=1.
REQ-013 colour  out  3  pixel colour.
REQ-014 busy  out  1  high while a draw pass is in progress.
REQ-015 done  out  1  one-cycle pulse at the end of a pass.
REQ-016 brick_hit  out  1  one-cycle pulse when a probe destroys a brick.
REQ-017 bricks_left  out  6  count of alive bricks.

Function
REQ-018 Geometry: brick (r,c) SHALL occupy x in [c*BRICK_W, c*BRICK_W+BRICK_W-2] and y in [Y_ORIGIN+r*BRICK_H, Y_ORIGIN+r*BRICK_H+BRICK_H-2].
REQ-019 State: one alive bit per brick (ROWS*COLS bits).
REQ-020 FSM states and transitions:
- IDLE: go=1 -> DRAW.
- DRAW: after the last pixel of the last brick -> DONE.
- DONE: one cycle, then -> IDLE.
REQ-021 go SHALL be ignored while in DRAW or DONE.
REQ-022 DRAW scan order:
- pixel x-offset 0..BRICK_W-2 inner loop, y-offset 0..BRICK_H-2 next loop;
- then brick column 0..COLS-1, then row 0..ROWS-1;
- one pixel per cycle, no gaps.
REQ-023 Every brick, alive or dead, SHALL be drawn each pass; 76 pixels/brick and 2432 writeEn cycles per pass at defaults.
REQ-024 Timing: go sampled at edge N -> first writeEn with (x,y)=(0,Y_ORIGIN) at cycle N+1; done SHALL be high the cycle after the last pixel.
REQ-025 Outputs x_out, y_out, writeEn and busy SHALL be registered.
REQ-026 colour SHALL reflect the alive bit at the cycle of output.
REQ-027 Colour by row for alive bricks: row0 3'b100, row1 3'b110, row2 3'b010, row3 3'b011, other rows 3'b111; dead bricks 3'b000.
REQ-028 busy=1 in DRAW and DONE; writeEn=0 outside DRAW.
REQ-029 Probe: on hit=1, if (hit_x,hit_y) lies inside the drawn rectangle of an alive brick, that brick's alive bit SHALL clear at the next edge, brick_hit SHALL pulse that same cycle, and bricks_left SHALL decrement by 1.
REQ-030 A probe in gap pixels, outside the field, or on a dead brick SHALL change nothing and produce no brick_hit.
REQ-031 Hit decode SHALL use range comparisons only (no divider); all coordinate arithmetic 10-bit unsigned.
REQ-032 Probes SHALL be serviced in every state, including mid-DRAW.
REQ-033 A brick cleared while it is being scanned SHALL output its remaining pixels as 3'b000.
REQ-034 bricks_left SHALL saturate at 0.

Reset
REQ-035 resetn=0 at an edge SHALL force IDLE, all bricks alive, bricks_left=32.
REQ-036 resetn=0 at an edge SHALL force writeEn=0, busy=0, done=0, brick_hit=0, x_out=0, y_out=0, colour=0.
REQ-037 Reset mid-DRAW SHALL abort the pass with no done pulse.
REQ-038 Reset SHALL take priority over go and hit in the same cycle.

Verification
REQ-039 Reset, go pulse -> 2432 consecutive writeEn cycles, first (0,10) colour 100, last (158,28) colour 011, then done for 1 cycle, busy low after.
REQ-040 hit at (25,16) -> brick (1,1) cleared, brick_hit pulse, bricks_left=31; next pass draws x 20..38, y 15..18 in 000.
REQ-041 hit at (19,10) gap, (5,30) below field, then (25,16) again -> no brick_hit, bricks_left unchanged.
REQ-042 go asserted again at pixel 100 of a pass -> pass unaffected, still exactly 2432 pixels and one done.
REQ-043 hit at (45,21) while scan is on brick (2,2) -> remaining pixels of that brick colour 000, brick_hit pulse.
REQ-044 resetn low at pixel 1000 -> writeEn=0 next cycle, no done pulse, bricks_left=32.

Source files
------------

// File: rtl/brick_draw.sv
// Brick-field renderer: scans every brick pixel-by-pixel on a go pulse and
// services ball probes that destroy bricks by range-compare hit decode.
module brick_draw #(
  parameter int COLS     = 8,
  parameter int ROWS     = 4,
  parameter int BRICK_W  = 20,
  parameter int BRICK_H  = 5,
  parameter int Y_ORIGIN = 10
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic       hit,
  input  logic [9:0] hit_x,
  input  logic [9:0] hit_y,
  output logic       writeEn,
  output logic [9:0] x_out,
  output logic [9:0] y_out,
  output logic [2:0] colour,
  output logic       busy,
  output logic       done,
  output logic       brick_hit,
  output logic [5:0] bricks_left
);

  localparam int N = ROWS * COLS;
  localparam logic [9:0] PX_LAST  = 10'(BRICK_W - 2);
  localparam logic [9:0] PY_LAST  = 10'(BRICK_H - 2);
  localparam logic [9:0] COL_LAST = 10'(COLS - 1);
  localparam logic [9:0] ROW_LAST = 10'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  state_t state, next_state;

  logic [N-1:0] alive;
  logic [9:0] px, py, col, row, bx, by;
  logic [9:0] px_n, py_n, col_n, row_n, bx_n, by_n;
  logic       last;
  logic       hit_ok;
  logic [31:0] hit_idx;
  logic [31:0] cur_idx;
  logic       cur_alive;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    last = (px == PX_LAST) && (py == PY_LAST) && (col == COL_LAST) && (row == ROW_LAST);
    case (state)
      IDLE:    if (go) next_state = DRAW;
      DRAW:    if (last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Scan counters point at the pixel being presented; bx/by track brick origins
  // incrementally so no multiplier sits on the pixel path.
  always_comb begin
    px_n = px; py_n = py; col_n = col; row_n = row; bx_n = bx; by_n = by;
    if (state == IDLE && go) begin
      px_n = '0; py_n = '0; col_n = '0; row_n = '0; bx_n = '0;
      by_n = 10'(Y_ORIGIN);
    end else if (state == DRAW && !last) begin
      if (px != PX_LAST) begin
        px_n = px + 10'd1;
      end else begin
        px_n = '0;
        if (py != PY_LAST) begin
          py_n = py + 10'd1;
        end else begin
          py_n = '0;
          if (col != COL_LAST) begin
            col_n = col + 10'd1;
            bx_n  = bx + 10'(BRICK_W);
          end else begin
            col_n = '0;
            bx_n  = '0;
            row_n = row + 10'd1;
            by_n  = by + 10'(BRICK_H);
          end
        end
      end
    end
  end

  always_comb begin
    hit_ok  = 1'b0;
    hit_idx = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (hit_x >= 10'(c * BRICK_W) && hit_x <= 10'(c * BRICK_W + BRICK_W - 2) &&
            hit_y >= 10'(Y_ORIGIN + r * BRICK_H) &&
            hit_y <= 10'(Y_ORIGIN + r * BRICK_H + BRICK_H - 2) &&
            alive[r * COLS + c]) begin
          hit_ok  = hit;
          hit_idx = 32'(r * COLS + c);
        end
      end
    end
  end

  // Colour follows the live alive bit so a brick cleared mid-scan blanks at once.
  always_comb begin
    cur_idx   = 32'(row) * 32'(COLS) + 32'(col);
    cur_alive = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i == cur_idx) cur_alive = alive[i];
    end
    colour = '0;
    if (writeEn && cur_alive) begin
      case (row)
        10'd0:   colour = 3'b100;
        10'd1:   colour = 3'b110;
        10'd2:   colour = 3'b010;
        10'd3:   colour = 3'b011;
        default: colour = 3'b111;
      endcase
    end
  end

  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      px <= '0; py <= '0; col <= '0; row <= '0; bx <= '0; by <= '0;
      x_out       <= '0;
      y_out       <= '0;
      writeEn     <= 1'b0;
      busy        <= 1'b0;
      brick_hit   <= 1'b0;
      alive       <= '1;
      bricks_left <= 6'(N);
    end else begin
      px <= px_n; py <= py_n; col <= col_n; row <= row_n; bx <= bx_n; by <= by_n;
      x_out     <= bx_n + px_n;
      y_out     <= by_n + py_n;
      writeEn   <= (next_state == DRAW);
      busy      <= (next_state != IDLE);
      brick_hit <= hit_ok;
      if (hit_ok) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (i == hit_idx) alive[i] <= 1'b0;
        end
        if (bricks_left != '0) bricks_left <= bricks_left - 6'd1;
      end
    end
  end

endmodule
